csr_trap_seq: RTL
=================

# csr_trap_seq

Trap-entry and `mret` sequencer for the machine-mode CSR file. Owns the CSR file's single write port and its combinational read port. Serialises the multi-register updates of a trap (mepc, mcause, mstatus) and of `mret` (mstatus), then issues a PC redirect. While idle, it passes instruction-driven CSR accesses (csrrw/csrrs) straight through; while busy, it stalls them. Sits between the decode/execute stage and the CSR file, alongside branch-target selection.

## Interface
- No parameters.
- `clk  in  1` — core clock; also drives the CSR file's write clock.
- `rst  in  1` — synchronous, active-high reset.
- `trap_req  in  1` — trap request (ecall); sampled only in IDLE.
- `trap_cause  in  32` — mcause value, latched on accept.
- `trap_pc  in  32` — faulting PC, latched on accept and written to mepc.
- `mret_req  in  1` — mret request; sampled only in IDLE.
- `inst_wr_en, inst_wr_set  in  1` — instruction CSR write strobe / set-mode (OR into register).
- `inst_wr_reg  in  12`, `inst_wr_bus  in  32` — instruction CSR write address / data.
- `inst_rd_reg  in  12` — instruction CSR read address.
- `inst_rd_bus  out  32` — instruction CSR read data.
- `csr_wr_en, csr_wr_set  out  1` — to the CSR file.
- `csr_wr_reg  out  12`, `csr_wr_bus  out  32` — to the CSR file.
- `csr_rd_reg  out  12` — to the CSR file.
- `csr_rd_bus  in  32` — from the CSR file (combinational).
- `mtvec, mepc  in  32` — exposed CSR values.
- `busy  out  1` — high in every state except IDLE; the core stalls on it.
- `redirect_valid  out  1` — one-cycle pulse.
- `redirect_pc  out  32` — target PC; valid with `redirect_valid`, 0 otherwise.

## Operation
- States: IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, M_MSTATUS, REDIRECT.
- IDLE:
  - CSR ports mirror the `inst_*` ports; `inst_rd_bus = csr_rd_bus`.
  - `trap_req` → latch `trap_pc` and `trap_cause`; go to T_MEPC.
  - Otherwise `mret_req` → go to M_MSTATUS, or straight to REDIRECT when the mstatus feature is out.
  - Both requests in the same cycle: trap wins; the mret is dropped.
  - An instruction write in the accept cycle still passes through that cycle.
- Busy states:
  - `inst_*` writes are blocked and `inst_rd_bus = 0`.
  - The sequencer drives every write with `csr_wr_set = 0` (plain overwrite).
- T_MEPC: write 0x341 ← latched pc. → T_MCAUSE.
- T_MCAUSE: write 0x342 ← latched cause. → T_MSTATUS, or REDIRECT when the mstatus feature is out.
- T_MSTATUS:
  - `csr_rd_reg = 0x300`; call the value read `old`.
  - Write 0x300 ← `(old & ~0x1888) | (old[3] << 7) | 0x1800`: MPIE ← MIE, MIE ← 0, MPP ← 11.
  - → REDIRECT.
- M_MSTATUS:
  - `csr_rd_reg = 0x300`; call the value read `old`.
  - Write 0x300 ← `(old & ~0x88) | (old[7] << 3) | 0x1880`: MIE ← MPIE, MPIE ← 1, MPP stays 11 (M-only core).
  - → REDIRECT.
- REDIRECT:
  - `redirect_valid = 1`, no CSR write.
  - `redirect_pc` = `mtvec` for a trap, `mepc` for an mret. A 1-bit kind register records which.
  - Values are read in this cycle, so they reflect all writes of the sequence.
  - → IDLE.
- Requests arriving while busy are ignored, not queued.

## Timing
- Reset state: IDLE. Latches, kind bit and all sequencer-driven outputs are 0: `busy = 0`, `redirect_valid = 0`, `redirect_pc = 0`, `csr_wr_en = 0` unless passing through.
- Reset mid-sequence: return to IDLE next edge. Any in-flight writes not yet issued are abandoned; no redirect is produced.
- Trap accepted at edge T: mepc write in cycle T+1, mcause in T+2, mstatus in T+3, redirect in T+4. `busy` is high T+1..T+4.
- mret accepted at T: mstatus write in T+1, redirect in T+2.
- Each write lands at the end of its cycle; the following state reads the updated value.

## Configuration
- `CSR_TRAP_MSTATUS_EN` defined: T_MSTATUS and M_MSTATUS are present as described.
- Not defined: both mstatus states are removed and mstatus is never written by the sequencer.
  - Trap redirect at T+3.
  - mret goes IDLE → REDIRECT, with redirect at T+1.

## Test plan
- Reset, then idle pass-through: after reset, `inst_wr_en = 1`, `inst_wr_reg = 0x305`, `inst_wr_bus = 0x80000100` → mtvec = 0x80000100. Reading 0x305 via `inst_rd_bus` returns it the next cycle; `busy = 0`.
- Trap entry: with mstatus = 0x1808, send a trap with pc 0x80000040, cause 11:
  - mepc = 0x80000040, mcause = 11.
  - mstatus = 0x1880.
  - `redirect_valid` pulses at T+4 with `redirect_pc = 0x80000100`; `busy` is high for exactly 4 cycles.
- mret: from mstatus 0x1880, send mret with mepc = 0x80000044 → mstatus = 0x1888; redirect to 0x80000044 at T+2.
- Collision: `trap_req` and `mret_req` in the same cycle → trap sequence only. A second `trap_req` during busy produces no second sequence.
- Blocking: `inst_wr_en` to 0x342 during T_MEPC → no write occurs and mcause ends as the trap cause.
- Reset at T+2 of a trap → IDLE next cycle, no redirect, mstatus unchanged. Also rerun trap and mret without `CSR_TRAP_MSTATUS_EN` → redirects at T+3 and T+1.

Source files
------------

// File: rtl/csr_trap_seq.sv
// Trap-entry / mret sequencer owning the CSR file's write and read ports.
// Optional mstatus update states are enabled by defining CSR_TRAP_MSTATUS_EN.
module csr_trap_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret_req,
  input  logic        inst_wr_en,
  input  logic        inst_wr_set,
  input  logic [11:0] inst_wr_reg,
  input  logic [31:0] inst_wr_bus,
  input  logic [11:0] inst_rd_reg,
  output logic [31:0] inst_rd_bus,
  output logic        csr_wr_en,
  output logic        csr_wr_set,
  output logic [11:0] csr_wr_reg,
  output logic [31:0] csr_wr_bus,
  output logic [11:0] csr_rd_reg,
  input  logic [31:0] csr_rd_bus,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

`ifdef CSR_TRAP_MSTATUS_EN
  typedef enum logic [2:0] {
    IDLE, T_MEPC, T_MCAUSE, T_MSTATUS, M_MSTATUS, REDIRECT
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, T_MEPC, T_MCAUSE, REDIRECT
  } state_t;
`endif

  state_t      state, next;
  logic [31:0] pc_q, cause_q;
  logic        kind_q;  // 1: trap (redirect to mtvec), 0: mret (redirect to mepc)

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      kind_q  <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE) begin
        if (trap_req) begin
          pc_q    <= trap_pc;
          cause_q <= trap_cause;
          kind_q  <= 1'b1;
        end else if (mret_req) begin
          kind_q  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    next           = state;
    busy           = 1'b1;
    csr_wr_en      = 1'b0;
    csr_wr_set     = 1'b0;
    csr_wr_reg     = '0;
    csr_wr_bus     = '0;
    csr_rd_reg     = '0;
    inst_rd_bus    = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      IDLE: begin
        busy        = 1'b0;
        csr_wr_en   = inst_wr_en;
        csr_wr_set  = inst_wr_set;
        csr_wr_reg  = inst_wr_reg;
        csr_wr_bus  = inst_wr_bus;
        csr_rd_reg  = inst_rd_reg;
        inst_rd_bus = csr_rd_bus;
        if (trap_req) next = T_MEPC;
`ifdef CSR_TRAP_MSTATUS_EN
        else if (mret_req) next = M_MSTATUS;
`else
        else if (mret_req) next = REDIRECT;
`endif
      end
      T_MEPC: begin
        csr_wr_en  = 1'b1;
        csr_wr_reg = 12'h341;
        csr_wr_bus = pc_q;
        next       = T_MCAUSE;
      end
      T_MCAUSE: begin
        csr_wr_en  = 1'b1;
        csr_wr_reg = 12'h342;
        csr_wr_bus = cause_q;
`ifdef CSR_TRAP_MSTATUS_EN
        next       = T_MSTATUS;
`else
        next       = REDIRECT;
`endif
      end
`ifdef CSR_TRAP_MSTATUS_EN
      T_MSTATUS: begin
        // MPIE <- MIE, MIE <- 0, MPP <- 11
        csr_rd_reg = 12'h300;
        csr_wr_en  = 1'b1;
        csr_wr_reg = 12'h300;
        csr_wr_bus = (csr_rd_bus & ~32'h0000_1888)
                   | {24'b0, csr_rd_bus[3], 7'b0} | 32'h0000_1800;
        next       = REDIRECT;
      end
      M_MSTATUS: begin
        // MIE <- MPIE, MPIE <- 1, MPP stays 11
        csr_rd_reg = 12'h300;
        csr_wr_en  = 1'b1;
        csr_wr_reg = 12'h300;
        csr_wr_bus = (csr_rd_bus & ~32'h0000_0088)
                   | {28'b0, csr_rd_bus[7], 3'b0} | 32'h0000_1880;
        next       = REDIRECT;
      end
`endif
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = kind_q ? mtvec : mepc;
        next           = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule
